dot_product_accumulator: RTL
============================

# dot_product_accumulator

Sequential accumulation stage directly downstream of the combinational `multiplier`. Consumes one `2*N`-bit product per accepted handshake and sums `LEN` consecutive products into one dot-product result. Presents the result on a valid/ready output port, then starts the next sum. Together with the multiplier, it forms the team's dot-product datapath.

## Interface
- `N`, default 8: operand width of the upstream multiplier; product width is `2*N`.
- `LEN`, default 4: products per dot product; legal range is `LEN >= 1`.
- `ACC_W` (derived, not overridable): `2*N + $clog2(LEN)`. This width is wide enough that the sum never overflows.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `clear`  in  1  synchronous abort: discards the partial sum or the held result.
- `in_valid`  in  1  `product` is valid.
- `in_ready`  out  1  block can accept a product this cycle.
- `product`  in  `2*N`  unsigned product from the multiplier.
- `out_valid`  out  1  `result` is valid.
- `out_ready`  in  1  downstream accepts `result`.
- `result`  out  `ACC_W`  unsigned dot product.
- `busy`  out  1  high when at least one product of the current sum has been accepted but the result is not yet presented.

## Operation
The state machine has two states: `ACCUM` and `HOLD`.

`ACCUM` state:
- `in_ready = 1`; `out_valid = 0`.
- An input transfer occurs when `in_valid && in_ready`. On a transfer with `cnt == 0`: `acc <= product` (zero-extended). With `cnt > 0`: `acc <= acc + product`.
- `cnt` increments on each transfer.
- On the transfer with `cnt == LEN-1`: go to `HOLD` and set `cnt <= 0`.
- When `in_valid` is low, `acc` and `cnt` hold.

`HOLD` state:
- `in_ready = 0`; `out_valid = 1`; `result = acc`.
- `result` stays stable while `out_valid && !out_ready`.
- On `out_valid && out_ready`: go to `ACCUM`. `acc` is not cleared; it is overwritten by the next first transfer.

`clear`:
- In any state, the next cycle is `ACCUM` with `cnt = 0` and `acc = 0`.
- In `HOLD`, the held result is lost and `out_valid` falls next cycle.
- Any input transfer or output handshake in the same cycle as `clear` is ignored. `in_ready` is still 1 in `ACCUM`, so upstream must not count that beat as consumed. Upstream drives `in_valid = 0` while asserting `clear`.

Other rules:
- Priority is `rst_n` > `clear` > handshakes.
- `busy = (state == ACCUM) && (cnt != 0)`.
- When `LEN = 1`, every transfer goes straight to `HOLD` with `acc = product`.
- Arithmetic is unsigned with no saturation; `ACC_W` guarantees no wrap.

## Timing
- Reset values: state `ACCUM`, `cnt = 0`, `acc = 0`, `in_ready = 1`, `out_valid = 0`, `result = 0`, `busy = 0`.
- Latency: `out_valid` rises the cycle after the `LEN`-th transfer.
- Throughput: with `out_ready` held high, one sum per `LEN + 1` cycles, because `HOLD` lasts at least one cycle.
- `in_ready` and `out_valid` are decoded only from registered state; there is no combinational path from any input to any output.
- `result` is driven from the `acc` register.
- Reset mid-sum drops the partial sum. Reset in `HOLD` drops the result, and `out_valid` is 0 on the next cycle.

## Structure
- Package `dot_product_pkg` holds:
  - the state enum `acc_state_t {ACCUM, HOLD}`;
  - the function `acc_width(N, LEN)` that returns `2*N + $clog2(LEN)`.
- The element counter is `$clog2(LEN)` bits wide, with a minimum of 1 bit.
- No sub-module. The counter and adder are inline.
- `multiplier` is instantiated beside this block at the top level, not inside it.

## Test plan
All scenarios use `N = 4`, `LEN = 4`, `ACC_W = 10` unless stated.

1. Reset and max-value sum: hold `rst_n = 0` for 2 cycles and check all reset values. Then send 4 back-to-back beats of `product = 225` with `out_ready = 1`. Expect `out_valid` for exactly one cycle with `result = 900`, then `in_ready` back to 1 on the following cycle.
2. Gapped input: send products 1, 2, 3, 4 with `in_valid` low for 2 cycles between beats. Expect `result = 10`, and `busy = 1` from the cycle after the first beat until `HOLD`.
3. Output backpressure: send products 10, 20, 30, 40 with `out_ready = 0` for 5 cycles. Expect `out_valid = 1` and `result = 100` stable, and `in_ready = 0` throughout. Raise `out_ready`; expect `ACCUM` on the next cycle.
4. Clear mid-sum: send 2 beats of value 50, then assert `clear` for one cycle. Then send 4 beats of value 1. Expect `result = 4`.
5. Reset in `HOLD`: send 7, 7, 7, 7, then assert `rst_n = 0` while `out_valid = 1`. Expect `out_valid = 0` and `result = 0` on the next cycle.
6. `LEN = 1`: products 3 and 5 back-to-back, with `out_ready = 1`. Expect results 3 and 5 on separate `out_valid` pulses, and `in_ready` low exactly one cycle after each beat.

Source files
------------

// File: rtl/dot_product_accumulator_pkg.sv
// dot_product_pkg: shared types and helpers for the dot-product accumulator.
//   acc_state_t : accumulator control state (ACCUM collects products,
//                 HOLD presents the finished sum)
//   acc_width() : result width that cannot overflow for LEN products of
//                 2*N bits each
package dot_product_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    function automatic int acc_width(input int n, input int len);
        return 2 * n + $clog2(len);
    endfunction

endpackage

// File: rtl/dot_product_accumulator_if.sv
// dot_product_accumulator_if: valid/ready product input and result output
// of the dot-product accumulator.
//   in_valid/in_ready/product  : product stream from the multiplier
//   out_valid/out_ready/result : finished dot product towards downstream
//   master : producer/consumer side (drives products, accepts results)
//   slave  : accumulator side
interface dot_product_accumulator_if #(
    parameter int N   = 8,
    parameter int LEN = 4
);
    localparam int ACC_W = dot_product_pkg::acc_width(N, LEN);

    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   product;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] result;

    modport master (
        output in_valid, product, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, product, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator: sums LEN consecutive unsigned 2*N-bit products
// into one dot product and presents it on a valid/ready output.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   clear : synchronous abort of the partial sum or held result
//   busy  : a sum is in progress (at least one product accepted, not done)
//   bus   : slave side of dot_product_accumulator_if (products in, result out)
module dot_product_accumulator
    import dot_product_pkg::*;
#(
    parameter int N   = 8,
    parameter int LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic busy,
    dot_product_accumulator_if.slave bus
);

    localparam int ACC_W = acc_width(N, LEN);
    // A 1-bit counter is kept even for LEN = 1, where it simply stays 0.
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    acc_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        if (clear) begin
            // Abort wins over any same-cycle input beat or output handshake.
            state_nxt = ACCUM;
            cnt_nxt   = '0;
            acc_nxt   = '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (bus.in_valid) begin
                        // First beat overwrites the previous sum instead of
                        // needing a separate clear of acc after each result.
                        if (cnt == '0) acc_nxt = ACC_W'(bus.product);
                        else           acc_nxt = acc + ACC_W'(bus.product);
                        if (cnt == CNT_LAST) begin
                            cnt_nxt   = '0;
                            state_nxt = HOLD;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) state_nxt = ACCUM;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACCUM;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
        end
    end

    // All outputs decode registered state only.
    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == HOLD);
    assign bus.result    = acc;
    assign busy          = (state == ACCUM) && (cnt != '0);

endmodule
